button_cmd_arbiter: RTL

//  Sequences several user buttons into one command stream. Per channel: rising-edge
//  (level-to-pulse) detection, one pending-press latch, round-robin grant.

---
 rtl/button_cmd_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/button_cmd_arbiter.sv
// Button press sequencer: per-channel edge detect, pending latch and round-robin grant
// onto a valid/ready command stream. Define AUTO_REPEAT_EN to add hold-to-repeat presses.
module button_cmd_arbiter #(
    parameter int NUM_BTN       = 4,
    parameter int ID_W          = 2,
    parameter int CNT_W         = 8,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] level,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output logic [ID_W-1:0]    cmd_id,
    output logic [NUM_BTN-1:0] pending,
    output logic [NUM_BTN-1:0] overrun
);

    // Handshake: a command transfers on a clock edge where cmd_valid and cmd_ready are
    // both high; while cmd_valid is high and cmd_ready is low, cmd_id holds its value.

    if (NUM_BTN > 2**ID_W) begin : g_bad_id_w
        $error("ID_W too narrow for NUM_BTN");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY <= REPEAT_PERIOD || REPEAT_DELAY > 2**CNT_W) begin : g_bad_repeat
        $error("repeat timing does not fit the counter");
    end

    typedef enum logic {ST_EMPTY = 1'b0, ST_VALID = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] overrun_q, overrun_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    cmd_id_q;
    logic [NUM_BTN-1:0] edge_press;
    logic [NUM_BTN-1:0] press;
    logic               grant_en;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic [NUM_BTN-1:0] grant_oh;

    assign edge_press = level & ~level_q;

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0]   rep_cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   rep_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] arm_q, arm_d;
    logic [NUM_BTN-1:0] rep_press;

    // Only a button pressed since reset is armed, so a hold through reset never repeats.
    always_comb begin
        rep_press = '0;
        arm_d     = arm_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            rep_press[i] = arm_q[i] & level[i] & ~edge_press[i] &
                           (rep_cnt_q[i] == CNT_W'(REPEAT_DELAY - 1));
            if (!level[i]) begin
                arm_d[i]     = 1'b0;
                rep_cnt_d[i] = '0;
            end else if (edge_press[i]) begin
                arm_d[i]     = 1'b1;
                rep_cnt_d[i] = '0;
            end else if (rep_press[i]) begin
                rep_cnt_d[i] = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= '0;
        end else begin
            arm_q <= arm_d;
            for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= rep_cnt_d[i];
        end
    end

    assign press = edge_press | rep_press;
`else
    assign press = edge_press;
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_BTN);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (grant_found) begin
                    grant_en = 1'b1;
                    state_d  = ST_VALID;
                end
            end
            ST_VALID: begin
                if (cmd_ready) begin
                    if (grant_found) grant_en = 1'b1;
                    else             state_d  = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        cmd_valid = (state_q == ST_VALID);
    end

    // A press in the grant cycle re-sets the bit being cleared, so it is kept.
    always_comb begin
        grant_oh  = grant_en ? (NUM_BTN'(1) << grant_idx) : '0;
        pending_d = (pending_q & ~grant_oh) | press;
        overrun_d = press & pending_q & ~grant_oh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= '1;
            pending_q <= '0;
            overrun_q <= '0;
            rr_ptr_q  <= ID_W'(NUM_BTN - 1);
            cmd_id_q  <= '0;
        end else begin
            level_q   <= level;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (grant_en) begin
                rr_ptr_q <= grant_idx;
                cmd_id_q <= grant_idx;
            end
        end
    end

    assign cmd_id  = cmd_id_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule
